// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file bank: controller state
// encodings and default geometry.
package regfile_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_state_e;

endpackage : regfile_pkg

// File: rtl/regfile_clear_ctrl.sv
// Clear sequencer: walks the whole array writing zero, one entry per cycle.
// Busy is high for exactly DEPTH cycles per sequence. A clear request that
// arrives while a sequence is running does not restart it.
module regfile_clear_ctrl
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  output logic              busy,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              clr_we
);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // State and counter registers; reset starts a fresh clear from entry 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter advance and clear-write strobe.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy     = 1'b0;
    clr_we   = 1'b0;
    clr_addr = cnt_q;
    unique case (state_q)
      CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        if (&cnt_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

endmodule : regfile_clear_ctrl

// File: rtl/regfile_bank.sv
// Register-file bank: one write port, two registered read ports with
// write-to-read bypass, and a multi-cycle clear sequence.
module regfile_bank
  import regfile_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int ZERO_REG0 = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [ADDR_W-1:0] D_address,
  input  logic [WIDTH-1:0]  data_in,
  input  logic [ADDR_W-1:0] A_address,
  input  logic [ADDR_W-1:0] B_address,
  input  logic              clear,
  output logic [WIDTH-1:0]  A_out,
  output logic [WIDTH-1:0]  B_out,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              d_we;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;

  regfile_clear_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_clear_ctrl (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .busy     (busy),
    .clr_addr (clr_addr),
    .clr_we   (clr_we)
  );

  // D-port write qualification and the clear-vs-D write mux.
  // clear wins over a same-cycle write; entry 0 is read-only when hardwired.
  always_comb begin
    d_we      = write && !busy && !clear &&
                !((ZERO_REG0 != 0) && (D_address == '0));
    mem_we    = !reset && (clr_we || d_we);
    mem_waddr = clr_we ? clr_addr : D_address;
    mem_wdata = clr_we ? '0 : data_in;
  end

  // Storage array; not reset, only zeroed by the clear sequence.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Read-port next values: zero while busy, hardwired entry 0, bypass, array.
  always_comb begin
    a_d = mem_q[A_address];
    b_d = mem_q[B_address];
    if (d_we && (D_address == A_address)) a_d = data_in;
    if (d_we && (D_address == B_address)) b_d = data_in;
    if ((ZERO_REG0 != 0) && (A_address == '0)) a_d = '0;
    if ((ZERO_REG0 != 0) && (B_address == '0)) b_d = '0;
    if (busy) begin
      a_d = '0;
      b_d = '0;
    end
  end

  // Registered read outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign A_out = a_q;
  assign B_out = b_q;

endmodule : regfile_bank

// File: tb/tb_regfile_bank.sv
// Randomized and directed bench for regfile_bank. Two instances share the
// same stimulus: one plain, one with entry 0 hardwired to zero.
module tb_regfile_bank;

  localparam int W     = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset, write, clear;
  logic [AW-1:0] d_addr, a_addr, b_addr;
  logic [W-1:0]  din;
  logic [W-1:0]  a_out0, b_out0, a_out1, b_out1;
  logic          busy0, busy1;

  always #5 clk = ~clk;

  regfile_bank #(.WIDTH(W), .ADDR_W(AW), .ZERO_REG0(0)) dut0 (
    .clk(clk), .reset(reset), .write(write), .D_address(d_addr),
    .data_in(din), .A_address(a_addr), .B_address(b_addr), .clear(clear),
    .A_out(a_out0), .B_out(b_out0), .busy(busy0)
  );

  regfile_bank #(.WIDTH(W), .ADDR_W(AW), .ZERO_REG0(1)) dut1 (
    .clk(clk), .reset(reset), .write(write), .D_address(d_addr),
    .data_in(din), .A_address(a_addr), .B_address(b_addr), .clear(clear),
    .A_out(a_out1), .B_out(b_out1), .busy(busy1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: array contents, cycles of clearing left, expected outputs.
  logic [W-1:0] mdl_mem [2][DEPTH];
  int           busy_left = 0;
  int           clr_idx   = 0;
  logic [W-1:0] exp_a [2];
  logic [W-1:0] exp_b [2];

  function automatic logic [W-1:0] mdl_read(int z, int addr, logic wr_ok, int da, logic [W-1:0] dv);
    if (z == 1 && addr == 0) return '0;
    if (wr_ok && da == addr) return dv;
    return mdl_mem[z][addr];
  endfunction

  task automatic model_edge();
    logic was_busy;
    logic wr_ok;
    was_busy = (busy_left > 0);
    for (int z = 0; z < 2; z++) begin
      if (reset) begin
        exp_a[z] = '0;
        exp_b[z] = '0;
      end else if (was_busy) begin
        mdl_mem[z][clr_idx] = '0;
        exp_a[z] = '0;
        exp_b[z] = '0;
      end else begin
        wr_ok = write && !clear && !(z == 1 && d_addr == 0);
        exp_a[z] = mdl_read(z, int'(a_addr), wr_ok, int'(d_addr), din);
        exp_b[z] = mdl_read(z, int'(b_addr), wr_ok, int'(d_addr), din);
        if (wr_ok) mdl_mem[z][d_addr] = din;
      end
    end
    if (reset) begin
      busy_left = DEPTH;
      clr_idx   = 0;
    end else if (was_busy) begin
      busy_left--;
      clr_idx++;
    end else if (clear) begin
      busy_left = DEPTH;
      clr_idx   = 0;
    end
  endtask

  // One clock cycle: drive, let the edge happen, update model, check.
  task automatic cyc(input logic rst, input logic wr, input logic [AW-1:0] da,
                     input logic [W-1:0] dv, input logic [AW-1:0] aa,
                     input logic [AW-1:0] ba, input logic clr);
    reset  = rst;
    write  = wr;
    d_addr = da;
    din    = dv;
    a_addr = aa;
    b_addr = ba;
    clear  = clr;
    @(posedge clk);
    model_edge();
    #1;
    check("busy0", 32'(busy0), 32'(busy_left > 0));
    check("busy1", 32'(busy1), 32'(busy_left > 0));
    check("A0", 32'(a_out0), 32'(exp_a[0]));
    check("B0", 32'(b_out0), 32'(exp_b[0]));
    check("A1", 32'(a_out1), 32'(exp_a[1]));
    check("B1", 32'(b_out1), 32'(exp_b[1]));
    @(negedge clk);
  endtask

  task automatic idle(input logic [AW-1:0] aa, input logic [AW-1:0] ba);
    cyc(1'b0, 1'b0, '0, '0, aa, ba, 1'b0);
  endtask

  int busy_cnt;

  initial begin
    for (int z = 0; z < 2; z++)
      for (int i = 0; i < DEPTH; i++) mdl_mem[z][i] = '0;
    reset = 1'b1; write = 1'b0; clear = 1'b0;
    d_addr = '0; din = '0; a_addr = '0; b_addr = '0;
    @(negedge clk);

    // Reset then count busy cycles; read every entry afterwards.
    cyc(1'b1, 1'b0, '0, '0, '0, '0, 1'b0);
    check("rst_A", 32'(a_out0), 32'h0);
    check("rst_busy", 32'(busy0), 32'h1);
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy0) busy_cnt++;
      idle('0, '0);
    end
    check("busy_len_rst", 32'(busy_cnt), 32'd8);
    for (int i = 0; i < DEPTH; i++) begin
      idle(AW'(i), AW'(DEPTH - 1 - i));
      check("init_zero", 32'(a_out0), 32'h0);
    end

    // Basic writes and dual reads.
    cyc(1'b0, 1'b1, 3'd1, 8'hAA, '0, '0, 1'b0);
    cyc(1'b0, 1'b1, 3'd2, 8'h01, '0, '0, 1'b0);
    cyc(1'b0, 1'b1, 3'd3, 8'h02, '0, '0, 1'b0);
    cyc(1'b0, 1'b1, 3'd4, 8'h03, '0, '0, 1'b0);
    idle(3'd2, 3'd1);
    check("rd_A2", 32'(a_out0), 32'h01);
    check("rd_B1", 32'(b_out0), 32'hAA);
    idle(3'd3, 3'd3);
    check("same_A", 32'(a_out0), 32'h02);
    check("same_B", 32'(b_out0), 32'h02);

    // Bypass.
    cyc(1'b0, 1'b1, 3'd5, 8'h5C, 3'd5, 3'd1, 1'b0);
    check("bypass", 32'(a_out0), 32'h5C);

    // Fill with 0xFF, clear, try a write while busy.
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, AW'(i), 8'hFF, '0, '0, 1'b0);
    cyc(1'b0, 1'b0, '0, '0, '0, '0, 1'b1);
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy0) busy_cnt++;
      cyc(1'b0, (i == 2), 3'd6, 8'h33, 3'd6, '0, 1'b0);
    end
    check("busy_len_clr", 32'(busy_cnt), 32'd8);
    for (int i = 0; i < DEPTH; i++) begin
      idle(AW'(i), AW'(i));
      check("cleared", 32'(a_out0), 32'h0);
    end

    // Clear interrupted by reset on its 4th cycle.
    cyc(1'b0, 1'b0, '0, '0, '0, '0, 1'b1);
    idle('0, '0);
    idle('0, '0);
    idle('0, '0);
    cyc(1'b1, 1'b0, '0, '0, '0, '0, 1'b0);
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy0) busy_cnt++;
      idle('0, '0);
    end
    check("busy_len_rst2", 32'(busy_cnt), 32'd8);

    // Hardwired entry 0 on dut1.
    cyc(1'b0, 1'b1, 3'd0, 8'h77, 3'd0, 3'd0, 1'b0);
    check("z0_bypass", 32'(a_out1), 32'h0);
    check("nz0_bypass", 32'(a_out0), 32'h77);
    idle(3'd0, 3'd0);
    check("z0_read", 32'(a_out1), 32'h0);
    cyc(1'b0, 1'b1, 3'd7, 8'h77, '0, '0, 1'b0);
    idle(3'd7, 3'd0);
    check("z7_read", 32'(a_out1), 32'h77);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] da, aa, ba;
      da = AW'($urandom_range(0, DEPTH - 1));
      aa = ($urandom_range(0, 3) == 0) ? da : AW'($urandom_range(0, DEPTH - 1));
      ba = ($urandom_range(0, 3) == 0) ? da : AW'($urandom_range(0, DEPTH - 1));
      cyc(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)), da,
          W'($urandom), aa, ba, ($urandom_range(0, 49) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_regfile_bank

// File: doc/regfile_bank.md
REGFILE_BANK -- requirements
Module: regfile_bank

Interface
REQ-001 Parameter WIDTH, default 8, data width of every entry and read/write port, in bits.
REQ-002 Parameter ADDR_W, default 3, address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter ZERO_REG0, default 0, when 1 entry 0 is hardwired to zero.
REQ-004 Port clk  input  1  single clock, all state updates on rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port write  input  1  write enable for D port.
REQ-007 Port D_address  input  ADDR_W  write address.
REQ-008 Port data_in  input  WIDTH  write data.
REQ-009 Port A_address  input  ADDR_W  read port A address.
REQ-010 Port B_address  input  ADDR_W  read port B address.
REQ-011 Port clear  input  1  request to zero all entries.
REQ-012 Port A_out  output  WIDTH  registered read data, port A.
REQ-013 Port B_out  output  WIDTH  registered read data, port B.
REQ-014 Port busy  output  1  high while clear sequence runs; writes and reads are not serviced.

Function
REQ-015 Controller states: IDLE and CLEAR; reset forces CLEAR with clear counter = 0.
REQ-016 In CLEAR, each cycle writes 0 to entry[counter] and increments counter; after entry DEPTH-1 is written, next state is IDLE.
REQ-017 After reset deasserts, busy stays high exactly DEPTH cycles, then falls.
REQ-018 clear=1 sampled in IDLE -> CLEAR next cycle, counter = 0; clear sampled in CLEAR is ignored (no restart).
REQ-019 In IDLE, write=1 updates entry[D_address] with data_in at the clock edge.
REQ-020 In CLEAR, write is ignored.
REQ-021 Read latency 1 cycle: A_out/B_out at edge N+1 reflect addresses sampled at edge N.
REQ-022 Bypass: write=1 in IDLE with D_address == A_address (or B_address) in the same cycle -> that port returns data_in, not the old entry.
REQ-023 A and B may read the same address simultaneously; both return the same value.
REQ-024 ZERO_REG0=1: writes to address 0 discarded, reads of address 0 return 0, bypass to address 0 suppressed.
REQ-025 While busy=1, A_out and B_out register 0.
REQ-026 clear and write both high in IDLE: clear wins, the write is discarded.
REQ-027 Address arithmetic is unsigned modulo DEPTH; the counter does not wrap past DEPTH-1 within one sequence.

Reset
REQ-028 reset=1 at an edge: A_out=0, B_out=0, busy=1, state=CLEAR, counter=0.
REQ-029 reset asserted mid-CLEAR restarts the clear from entry 0.
REQ-030 Storage array has no direct reset; it is zeroed only by the CLEAR sequence.

Structure
REQ-031 Shared package regfile_pkg holds state encodings (IDLE, CLEAR) and default WIDTH/ADDR_W constants.
REQ-032 One sub-module regfile_clear_ctrl implements the FSM and counter and drives busy, clear address and clear write strobe.
REQ-033 Top level contains the storage array, write mux (clear vs. D port), bypass logic and output registers.

Verification
REQ-034 Reset 1 cycle, then hold idle -> busy high 8 cycles (defaults), then low; all 8 addresses read 0x00.
REQ-035 Write 0xAA@1, 0x01@2, 0x02@3, 0x03@4; then A_address=2, B_address=1 -> next cycle A_out=0x01, B_out=0xAA.
REQ-036 write=1, D_address=5, data_in=0x5C with A_address=5 in the same cycle -> next cycle A_out=0x5C (bypass).
REQ-037 Fill entries with 0xFF, pulse clear -> busy 8 cycles, write of 0x33@6 during busy dropped, afterwards every read returns 0x00.
REQ-038 reset pulsed on 4th CLEAR cycle -> busy remains high 8 further cycles from the reset release.
REQ-039 ZERO_REG0=1: write 0x77@0, read A_address=0 -> A_out=0x00; write 0x77@7 -> read 0x77.
